// File: rtl/fetch_aligner.sv
// Fetch-stage byte aligner: two-line window over the I-cache stream that presents
// the 16 bytes at the fetch EIP and keeps the window filled with sequential lines.
module fetch_aligner #(
    parameter logic [31:0] RESET_EIP = 32'hFFFF_FFF0
) (
    input  logic         clk,
    input  logic         clr,
    output logic         line_req_valid,
    output logic [31:0]  line_req_addr,
    input  logic         line_resp_valid,
    input  logic [127:0] line_resp_data,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_target,
    input  logic         consume_valid,
    input  logic [3:0]   consume_len,
    output logic [127:0] packet_out,
    output logic         valid_out,
    output logic [31:0]  eip_out
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } req_state_t;

    req_state_t    state;
    logic [31:0]   eip;
    logic [127:0]  lo_data;
    logic [127:0]  hi_data;
    logic          lo_v;
    logic          hi_v;

    logic [3:0]    off;
    logic [6:0]    shamt;
    logic [4:0]    off_sum;
    logic          take;
    logic [27:0]   next_line;

    assign off       = eip[3:0];
    assign shamt     = {off, 3'b000};
    assign off_sum   = {1'b0, off} + {1'b0, consume_len};
    assign take      = consume_valid && valid_out && (consume_len != 4'd0);
    assign next_line = eip[31:4] + 28'd1;

    assign valid_out  = lo_v && ((off == 4'd0) || hi_v);
    assign packet_out = 128'({hi_data, lo_data} >> shamt);
    assign eip_out    = eip;

    // Window, EIP and request FSM. Later non-blocking writes override earlier ones,
    // so the consume shift is naturally ordered before the response write.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state          <= IDLE;
            eip            <= RESET_EIP;
            lo_data        <= '0;
            hi_data        <= '0;
            lo_v           <= 1'b0;
            hi_v           <= 1'b0;
            line_req_valid <= 1'b0;
            line_req_addr  <= {RESET_EIP[31:4], 4'h0};
        end else begin
            line_req_valid <= 1'b0;
            if (redirect_valid) begin
                eip  <= redirect_target;
                lo_v <= 1'b0;
                hi_v <= 1'b0;
                // A response landing with the redirect completes the outstanding request.
                if (state != IDLE) begin
                    state <= line_resp_valid ? IDLE : DROP;
                end
            end else begin
                if (take) begin
                    eip <= eip + 32'(consume_len);
                    if (off_sum[4]) begin
                        lo_data <= hi_data;
                        hi_v    <= 1'b0;
                    end
                end
                case (state)
                    IDLE: begin
                        if (!lo_v) begin
                            line_req_valid <= 1'b1;
                            line_req_addr  <= {eip[31:4], 4'h0};
                            state          <= WAIT;
                        end else if (!hi_v) begin
                            line_req_valid <= 1'b1;
                            line_req_addr  <= {next_line, 4'h0};
                            state          <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (line_resp_valid) begin
                            if (!lo_v) begin
                                lo_data <= line_resp_data;
                                lo_v    <= 1'b1;
                            end else begin
                                hi_data <= line_resp_data;
                                hi_v    <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                    DROP: begin
                        if (line_resp_valid) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
